// File: rtl/zbb_count_unit_if.sv
// ============================================================================
// Module : zbb_count_unit_if
// Brief  : Operand/result handshake bundle for the Zbb counting unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface zbb_count_unit_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] operand;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, operand, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, operand, out_ready,
        output in_ready, out_valid, result
    );
endinterface

`default_nettype wire

// File: rtl/zbb_count_unit.sv
// ============================================================================
// Module : zbb_count_unit
// Brief  : Multi-cycle CPOP/CLZ/CTZ unit, CHUNK bits per cycle.
//          Optional macro ZBB_EARLY_EXIT_EN ends CLZ/CTZ at the first nonzero chunk.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module zbb_count_unit #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    zbb_count_unit_if.slave bus
);
    localparam int NCH  = XLEN / CHUNK;
    localparam int AW   = $clog2(XLEN) + 1;
    localparam int CNTW = $clog2(CHUNK) + 1;
    localparam int IW   = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_opnd;
    logic [1:0]        r_op;
    logic [AW-1:0]     r_acc;
    logic [IW-1:0]     r_idx;
    logic              r_found;
    logic [AW-1:0]     r_result;

    logic              w_msb_first;
    logic              w_zero_cnt;
    logic [CHUNK-1:0]  w_chunk;
    logic              w_chunk_nz;
    logic              w_last;
    logic              w_early;
    logic              w_finish;
    logic [AW-1:0]     w_acc_nxt;
    logic              w_found_nxt;

    function automatic logic [CNTW-1:0] f_popcount(input logic [CHUNK-1:0] v);
        logic [CNTW-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK; i++) begin
            n = n + CNTW'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [CNTW-1:0] f_lead_zeros(input logic [CHUNK-1:0] v);
        logic [CNTW-1:0] n;
        logic            seen;
        n    = '0;
        seen = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (v[i]) seen = 1'b1;
            else if (!seen) n = n + CNTW'(1);
        end
        return n;
    endfunction

    function automatic logic [CNTW-1:0] f_trail_zeros(input logic [CHUNK-1:0] v);
        logic [CNTW-1:0] n;
        logic            seen;
        n    = '0;
        seen = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (v[i]) seen = 1'b1;
            else if (!seen) n = n + CNTW'(1);
        end
        return n;
    endfunction

    // op 2'b11 is reserved and falls through to CPOP
    assign w_msb_first = (r_op == 2'b01);
    assign w_zero_cnt  = (r_op == 2'b01) || (r_op == 2'b10);

    // The working copy is shifted each cycle so the current chunk is always at a fixed end
    assign w_chunk    = w_msb_first ? r_opnd[XLEN-1 -: CHUNK] : r_opnd[CHUNK-1:0];
    assign w_chunk_nz = |w_chunk;
    assign w_last     = (r_idx == IW'(NCH - 1));

`ifdef ZBB_EARLY_EXIT_EN
    assign w_early = w_zero_cnt && !r_found && w_chunk_nz;
`else
    assign w_early = 1'b0;
`endif

    assign w_finish = w_last || w_early;

    always_comb begin
        w_acc_nxt   = r_acc;
        w_found_nxt = r_found;
        if (!w_zero_cnt) begin
            w_acc_nxt = r_acc + AW'(f_popcount(w_chunk));
        end else if (!r_found) begin
            if (w_chunk_nz) begin
                w_found_nxt = 1'b1;
                w_acc_nxt   = r_acc + (w_msb_first ? AW'(f_lead_zeros(w_chunk))
                                                   : AW'(f_trail_zeros(w_chunk)));
            end else begin
                w_acc_nxt = r_acc + AW'(CHUNK);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_finish)     w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_opnd   <= '0;
            r_op     <= 2'b00;
            r_acc    <= '0;
            r_idx    <= '0;
            r_found  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_opnd  <= bus.operand;
                        r_op    <= bus.op;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_found <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_acc   <= w_acc_nxt;
                    r_found <= w_found_nxt;
                    r_idx   <= r_idx + IW'(1);
                    r_opnd  <= w_msb_first ? (r_opnd << CHUNK) : (r_opnd >> CHUNK);
                    if (w_finish) r_result <= w_acc_nxt;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = {{(XLEN-AW){1'b0}}, r_result};

endmodule

`default_nettype wire
